// File: rtl/div4_seq.sv
// Sequential unsigned 4-bit restoring divider that drives an external 4-bit
// adder/subtractor stage and resolves one quotient bit per cycle.
module div4_seq #(
    parameter logic [3:0] DBZ_QUOTIENT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [3:0] quotient,
    output logic [3:0] remainder,
    output logic       div_by_zero,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    output logic       add_sub,
    input  logic [3:0] add_s,
    input  logic       add_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] rem_r;
    logic [3:0] dvd_r;
    logic [3:0] dvs_r;
    logic [1:0] cnt_r;
    logic [3:0] sh_s;
    logic [3:0] rem_nx_s;
    logic       qbit_s;

    // Next-state decode and adder-stage drive; the stage answers within the cycle
    always_comb begin
        state_s  = state_r;
        add_a    = 4'd0;
        add_b    = 4'd0;
        add_sub  = 1'b0;
        sh_s     = {rem_r[2:0], dvd_r[3]};
        rem_nx_s = sh_s;
        qbit_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (divisor == 4'd0) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                add_a   = sh_s;
                add_b   = dvs_r;
                add_sub = 1'b1;
                // carry-out in subtract mode means no borrow, i.e. sh >= divisor
                if (add_cout) begin
                    qbit_s   = 1'b1;
                    rem_nx_s = add_s;
                end else begin
                    qbit_s   = 1'b0;
                    rem_nx_s = sh_s;
                end
                if (cnt_r == 2'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and registered handshake flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_r <= state_s;
            busy    <= (state_s != IDLE);
            done    <= (state_s == DONE);
        end
    end

    // Working registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r       <= 4'd0;
            dvd_r       <= 4'd0;
            dvs_r       <= 4'd0;
            cnt_r       <= 2'd0;
            quotient    <= 4'd0;
            remainder   <= 4'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (divisor == 4'd0) begin
                            quotient    <= DBZ_QUOTIENT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            dvd_r       <= dividend;
                            dvs_r       <= divisor;
                            rem_r       <= 4'd0;
                            cnt_r       <= 2'd3;
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_nx_s;
                    dvd_r <= {dvd_r[2:0], qbit_s};
                    cnt_r <= cnt_r - 2'd1;
                    if (cnt_r == 2'd0) begin
                        quotient  <= {dvd_r[2:0], qbit_s};
                        remainder <= rem_nx_s;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div4_seq.sv
// Scoreboard bench for div4_seq: stimulus queues expected results, a monitor
// pops and compares them on every done pulse. Also models the add/sub stage.
module tb_div4_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_sub;
    logic [3:0] add_s;
    logic       add_cout;
    logic [4:0] add_t;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [8:0] sb_q[$];

    div4_seq #(.DBZ_QUOTIENT(4'hF)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
        .add_a(add_a), .add_b(add_b), .add_sub(add_sub),
        .add_s(add_s), .add_cout(add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 4-bit adder/subtractor stage: Cin=1 inverts B and adds one
    always_comb begin
        add_t = 5'd0;
        if (add_sub) add_t = {1'b0, add_a} + {1'b0, ~add_b} + 5'd1;
        else         add_t = {1'b0, add_a} + {1'b0, add_b};
        add_s    = add_t[3:0];
        add_cout = add_t[4];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: q=%0d r=%0d dbz=%0d with empty scoreboard",
                         quotient, remainder, div_by_zero);
            end else begin
                logic [8:0] exp;
                exp = sb_q.pop_front();
                if ({quotient, remainder, div_by_zero} !== exp) begin
                    n_fail++;
                    $display("FAIL result: got q=%0d r=%0d dbz=%0d expected q=%0d r=%0d dbz=%0d",
                             quotient, remainder, div_by_zero, exp[8:5], exp[4:1], exp[0]);
                end
            end
        end
    end

    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, lat);
        end
    endtask

    task automatic do_op(input logic [3:0] n, input logic [3:0] d,
                         input logic [3:0] eq, input logic [3:0] er, input logic edbz);
        int lat;
        @(negedge clk);
        start = 1'b1; dividend = n; divisor = d;
        sb_q.push_back({eq, er, edbz});
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1);
        if (d != 4'd0) chk("add_sub_in_calc", add_sub, 1);
        wait_done("op", lat);
        chk("latency", lat, (d == 4'd0) ? 0 : 4);
        @(posedge clk); #1;
        chk("busy_back_idle", busy, 0);
        chk("done_one_cycle", done, 0);
    endtask

    initial begin
        int lat;
        int gap;
        rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_add_sub", add_sub, 0);
        chk("rst_add_a", add_a, 0);
        chk("rst_add_b", add_b, 0);

        // Directed vectors
        do_op(4'd13, 4'd3,  4'd4,  4'd1,  1'b0);
        do_op(4'd15, 4'd1,  4'd15, 4'd0,  1'b0);
        do_op(4'd14, 4'd15, 4'd0,  4'd14, 1'b0);
        do_op(4'd7,  4'd0,  4'hF,  4'd7,  1'b1);
        chk("dbz_holds_q", quotient, 15);
        do_op(4'd9,  4'd2,  4'd4,  4'd1,  1'b0);

        // Start during CALC is ignored
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        sb_q.push_back({4'd2, 4'd2, 1'b0});
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(negedge clk); start = 1'b0;
        wait_done("busy_start", lat);
        repeat (8) @(posedge clk);
        #1;
        chk("ignored_start_q", quotient, 2);

        // Held start: second op only after returning to IDLE
        @(negedge clk);
        start = 1'b1; dividend = 4'd9; divisor = 4'd2;
        sb_q.push_back({4'd4, 4'd1, 1'b0});
        sb_q.push_back({4'd4, 4'd1, 1'b0});
        @(posedge clk); #1;
        wait_done("held_first", lat);
        gap = 0;
        @(posedge clk); #1; gap++;
        while (!done && gap < 20) begin
            @(posedge clk); #1; gap++;
        end
        start = 1'b0;
        chk("held_start_gap", gap, 6);
        repeat (8) @(posedge clk);

        // Reset in the 2nd CALC cycle aborts with no done
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        chk("midrst_add_sub", add_sub, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (8) @(posedge clk);
        do_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0);

        // Exhaustive sweep
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                if (d == 0) do_op(4'(n), 4'(d), 4'hF, 4'(n), 1'b1);
                else        do_op(4'(n), 4'(d), 4'(n / d), 4'(n % d), 1'b0);
            end
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
